// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, ALU operand/result bundle and
// debug register-read port of the ALU sequencer.
interface alu_sequencer_if #(
    parameter int N = 16
);
    logic [15:0]  instrIn;
    logic         instrValid;
    logic         instrReady;
    logic [N-1:0] aluOperand1;
    logic [N-1:0] aluOperand2;
    logic         aluCarryIn;
    logic [2:0]   aluOperation;
    logic         aluEnableAlu;
    logic         aluEnableShift;
    logic         aluEnableLoad;
    logic [N-1:0] aluResult;
    logic         aluCarryOut;
    logic         aluZeroOut;
    logic         aluNegativeOut;
    logic         carryFlag;
    logic         zeroFlag;
    logic         negativeFlag;
    logic         done;
    logic         illegal;
    logic [2:0]   dbgAddr;
    logic [N-1:0] dbgData;

    modport slave (
        input  instrIn, instrValid, aluResult, aluCarryOut, aluZeroOut, aluNegativeOut, dbgAddr,
        output instrReady, aluOperand1, aluOperand2, aluCarryIn, aluOperation,
               aluEnableAlu, aluEnableShift, aluEnableLoad,
               carryFlag, zeroFlag, negativeFlag, done, illegal, dbgData
    );

    modport master (
        output instrIn, instrValid, aluResult, aluCarryOut, aluZeroOut, aluNegativeOut, dbgAddr,
        input  instrReady, aluOperand1, aluOperand2, aluCarryIn, aluOperation,
               aluEnableAlu, aluEnableShift, aluEnableLoad,
               carryFlag, zeroFlag, negativeFlag, done, illegal, dbgData
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/READ/EXEC sequencer feeding an external ALU from an
// eight-entry register file and writing its result and flags back.
module alu_sequencer #(
    parameter int N = 16
) (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [15:0]  instr_q, instr_d;
    logic [N-1:0] regs_q [8];
    logic [N-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]   op_q, op_d, en_q, en_d;
    logic         cin_q, cin_d, done_q, done_d, illegal_q, illegal_d;
    logic         c_q, z_q, n_q;
    logic [1:0]   cls;
    logic [2:0]   rd, rs1, rs2;
    logic         imm_ld;

    assign cls = instr_q[15:14];
    assign rd  = instr_q[10:8];
    assign rs1 = instr_q[7:5];
    assign rs2 = instr_q[4:2];
    // Immediate loads merge a byte into the destination, so rd becomes the second operand
    assign imm_ld = cls == 2'b10 && instr_q[13];

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        op_d      = op_q;
        cin_d     = cin_q;
        en_d      = 3'b000;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        if (state_q == IDLE) begin
            instr_d = bus.instrValid ? bus.instrIn : instr_q;
            state_d = bus.instrValid ? READ : IDLE;
        end else if (state_q == READ && cls == 2'b11) begin
            state_d   = IDLE;
            illegal_d = 1'b1;
        end else if (state_q == READ) begin
            op1_d   = imm_ld ? N'({2{instr_q[7:0]}}) : regs_q[rs1];
            op2_d   = imm_ld ? regs_q[rd] : regs_q[rs2];
            op_d    = instr_q[13:11];
            cin_d   = c_q;
            en_d    = 3'b001 << cls;
            state_d = EXEC;
        end else begin
            state_d = IDLE;
            done_d  = state_q == EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op_q      <= '0;
            cin_q     <= 1'b0;
            en_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            op_q      <= op_d;
            cin_q     <= cin_d;
            en_q      <= en_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            if (state_q == EXEC) begin
                regs_q[rd] <= bus.aluResult;
                c_q        <= bus.aluCarryOut;
                z_q        <= bus.aluZeroOut;
                n_q        <= bus.aluNegativeOut;
            end
        end
    end

    assign bus.instrReady     = state_q == IDLE;
    assign bus.aluOperand1    = op1_q;
    assign bus.aluOperand2    = op2_q;
    assign bus.aluOperation   = op_q;
    assign bus.aluCarryIn     = cin_q;
    assign bus.aluEnableAlu   = en_q[0];
    assign bus.aluEnableShift = en_q[1];
    assign bus.aluEnableLoad  = en_q[2];
    assign bus.carryFlag      = c_q;
    assign bus.zeroFlag       = z_q;
    assign bus.negativeFlag   = n_q;
    assign bus.done           = done_q;
    assign bus.illegal        = illegal_q;
    assign bus.dbgData        = regs_q[bus.dbgAddr];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against an
// instruction-level register/flag model, with a behavioural ALU attached.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp, n_err;

    alu_sequencer_if #(.N(16)) bus ();
    alu_sequencer #(.N(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // ALU: class 00 ADD/ADC/SUB/SBC/AND/OR/XOR/PASS, 01 SHL/SHR/ROL/ROR/ASR, 10 MOV or LDLI/LDHI/LDLZI/LDHZI
    function automatic logic [16:0] alu_f(input logic [1:0] c, input logic [2:0] op,
                                          input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] s;
        s = {ci, a};
        if (c == 2'd0) begin
            case (op)
                3'd0: s = {1'b0, a} + {1'b0, b};
                3'd1: s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
                3'd2: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                3'd3: s = {1'b0, a} + {1'b0, ~b} + {16'd0, ci};
                3'd4: s = {ci, a & b};
                3'd5: s = {ci, a | b};
                3'd6: s = {ci, a ^ b};
                default: s = {ci, a};
            endcase
        end else if (c == 2'd1) begin
            case (op)
                3'd0: s = {a, 1'b0};
                3'd1: s = {a[0], 1'b0, a[15:1]};
                3'd2: s = {a, ci};
                3'd3: s = {a[0], ci, a[15:1]};
                3'd4: s = {a[0], a[15], a[15:1]};
                default: s = {ci, a};
            endcase
        end else begin
            case (op)
                3'd4: s = {ci, b[15:8], a[7:0]};
                3'd5: s = {ci, a[15:8], b[7:0]};
                3'd6: s = {ci, 8'h00, a[7:0]};
                3'd7: s = {ci, a[15:8], 8'h00};
                default: s = {ci, a};
            endcase
        end
        return s;
    endfunction

    logic [2:0]  en_w;
    logic [1:0]  alu_cls;
    logic [16:0] alu_out;
    assign en_w    = {bus.aluEnableLoad, bus.aluEnableShift, bus.aluEnableAlu};
    assign alu_cls = bus.aluEnableShift ? 2'd1 : bus.aluEnableLoad ? 2'd2 : 2'd0;
    assign alu_out = alu_f(alu_cls, bus.aluOperation, bus.aluOperand1, bus.aluOperand2, bus.aluCarryIn);
    // Garbage outside an enabled cycle exposes a write-back at the wrong time
    assign bus.aluResult      = en_w != 3'b000 ? alu_out[15:0] : 16'hDEAD;
    assign bus.aluCarryOut    = en_w != 3'b000 ? alu_out[16] : 1'b1;
    assign bus.aluZeroOut     = en_w != 3'b000 ? alu_out[15:0] == 16'h0000 : 1'b1;
    assign bus.aluNegativeOut = en_w != 3'b000 ? alu_out[15] : 1'b1;

    logic [15:0] m_reg [8];
    logic        m_c, m_z, m_n;

    function automatic logic [15:0] enc(input logic [1:0] c, input logic [2:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2);
        return {c, o, d, s1, s2, 2'b00};
    endfunction

    function automatic logic [15:0] imm(input logic [2:0] o, input logic [2:0] d, input logic [7:0] v);
        return {2'b10, o, d, v};
    endfunction

    function automatic logic imm_ld(input logic [15:0] ins);
        return ins[15:14] == 2'b10 && ins[13];
    endfunction

    function automatic logic [15:0] m_a(input logic [15:0] ins);
        return imm_ld(ins) ? {ins[7:0], ins[7:0]} : m_reg[ins[7:5]];
    endfunction

    function automatic logic [15:0] m_b(input logic [15:0] ins);
        return imm_ld(ins) ? m_reg[ins[10:8]] : m_reg[ins[4:2]];
    endfunction

    function automatic logic [15:0] rand_instr(input bit allow_ill);
        logic [15:0] w;
        w = 16'($urandom);
        w[15:14] = (allow_ill && $urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return w;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_reg[r] = 16'h0000;
        m_c = 1'b0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    task automatic model_apply(input logic [15:0] ins);
        logic [16:0] s;
        if (ins[15:14] != 2'b11) begin
            s = alu_f(ins[15:14], ins[13:11], m_a(ins), m_b(ins), m_c);
            m_reg[ins[10:8]] = s[15:0];
            m_c = s[16];
            m_z = s[15:0] == 16'h0000;
            m_n = s[15];
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.instrValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_instr(input logic [15:0] ins);
        logic [1:0]  c;
        logic [15:0] ea, eb;
        int          w;
        c  = ins[15:14];
        ea = m_a(ins);
        eb = m_b(ins);
        @(negedge clk);
        bus.instrIn = ins;
        bus.instrValid = 1'b1;
        w = 0;
        while (bus.instrReady !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 8) begin
            n_err++;
            $display("FAIL accept: instrReady=%b, required 1 within 8 cycles (instr %h)", bus.instrReady, ins);
            bus.instrValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.instrValid = 1'b0;
        bus.instrIn = 16'($urandom);
        @(negedge clk);
        n_cmp++;
        if ({bus.instrReady, bus.done, bus.illegal, en_w} !== 6'b000000) begin
            n_err++;
            $display("FAIL read_cycle: rdy/done/ill/en=%b, required 000000 (instr %h)",
                     {bus.instrReady, bus.done, bus.illegal, en_w}, ins);
        end
        @(negedge clk);
        if (c == 2'b11) begin
            n_cmp++;
            if ({bus.illegal, bus.done, en_w, bus.instrReady} !== 6'b100001) begin
                n_err++;
                $display("FAIL illegal_pulse: ill/done/en/rdy=%b, required 100001 (instr %h)",
                         {bus.illegal, bus.done, en_w, bus.instrReady}, ins);
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.illegal, bus.done} !== 2'b00) begin
                n_err++;
                $display("FAIL illegal_width: ill/done=%b, required 00", {bus.illegal, bus.done});
            end
        end else begin
            n_cmp++;
            if (en_w !== 3'b001 << c) begin
                n_err++;
                $display("FAIL exec_enable: en=%b, required %b (instr %h)", en_w, 3'b001 << c, ins);
            end
            n_cmp++;
            if ({bus.aluOperand1, bus.aluOperand2, bus.aluOperation, bus.aluCarryIn} !== {ea, eb, ins[13:11], m_c}) begin
                n_err++;
                $display("FAIL exec_operands: op1=%h op2=%h op=%0d ci=%b, required %h %h %0d %b (instr %h)",
                         bus.aluOperand1, bus.aluOperand2, bus.aluOperation, bus.aluCarryIn,
                         ea, eb, ins[13:11], m_c, ins);
            end
            n_cmp++;
            if ({bus.done, bus.instrReady} !== 2'b00) begin
                n_err++;
                $display("FAIL exec_status: done/rdy=%b, required 00", {bus.done, bus.instrReady});
            end
            model_apply(ins);
            @(negedge clk);
            n_cmp++;
            if ({bus.done, bus.illegal, en_w, bus.instrReady} !== 6'b100001) begin
                n_err++;
                $display("FAIL done_pulse: done/ill/en/rdy=%b, required 100001 (instr %h)",
                         {bus.done, bus.illegal, en_w, bus.instrReady}, ins);
            end
        end
        n_cmp++;
        if ({bus.carryFlag, bus.zeroFlag, bus.negativeFlag} !== {m_c, m_z, m_n}) begin
            n_err++;
            $display("FAIL flags: CZN=%b, required %b (instr %h)",
                     {bus.carryFlag, bus.zeroFlag, bus.negativeFlag}, {m_c, m_z, m_n}, ins);
        end
        for (int r = 0; r < 8; r++) begin
            bus.dbgAddr = 3'(r);
            #1;
            n_cmp++;
            if (bus.dbgData !== m_reg[r]) begin
                n_err++;
                $display("FAIL reg R%0d: got %h, required %h (after instr %h)", r, bus.dbgData, m_reg[r], ins);
            end
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: done=%b one cycle after pulse, required 0", bus.done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instrValid = 1'b1;
        bus.instrIn = enc(2'd0, 3'd0, 3'd1, 3'd2, 3'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.instrReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset_priority: instrReady=%b under reset+valid, required 1", bus.instrReady);
        end
        bus.instrValid = 1'b0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.instrReady, bus.done, bus.illegal, en_w, bus.carryFlag, bus.zeroFlag, bus.negativeFlag} !== 9'b100000000) begin
            n_err++;
            $display("FAIL reset_status: rdy/done/ill/en/CZN=%b, required 100000000",
                     {bus.instrReady, bus.done, bus.illegal, en_w, bus.carryFlag, bus.zeroFlag, bus.negativeFlag});
        end
        n_cmp++;
        if ({bus.aluOperand1, bus.aluOperand2, bus.aluOperation, bus.aluCarryIn} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_operands: %h %h %0d %b, required all zero",
                     bus.aluOperand1, bus.aluOperand2, bus.aluOperation, bus.aluCarryIn);
        end
        for (int r = 0; r < 8; r++) begin
            bus.dbgAddr = 3'(r);
            #1;
            n_cmp++;
            if (bus.dbgData !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_reg R%0d: got %h, required 0000", r, bus.dbgData);
            end
        end
    endtask

    task automatic test_directed();
        reset_dut();
        run_instr(imm(3'd6, 3'd1, 8'h34));
        run_instr(imm(3'd5, 3'd1, 8'h12));
        bus.dbgAddr = 3'd1;
        #1;
        n_cmp++;
        if ({bus.dbgData, bus.carryFlag, bus.zeroFlag, bus.negativeFlag} !== {16'h1234, 3'b000}) begin
            n_err++;
            $display("FAIL ld_r1: R1=%h CZN=%b, required 1234 000",
                     bus.dbgData, {bus.carryFlag, bus.zeroFlag, bus.negativeFlag});
        end
        run_instr(imm(3'd6, 3'd3, 8'hFF));
        run_instr(imm(3'd5, 3'd3, 8'hFF));
        run_instr(enc(2'd0, 3'd0, 3'd4, 3'd3, 3'd1));
        bus.dbgAddr = 3'd4;
        #1;
        n_cmp++;
        if ({bus.dbgData, bus.carryFlag} !== {16'h1233, 1'b1}) begin
            n_err++;
            $display("FAIL add_r4: R4=%h C=%b, required 1233 1", bus.dbgData, bus.carryFlag);
        end
        run_instr(enc(2'd0, 3'd1, 3'd5, 3'd1, 3'd1));
        bus.dbgAddr = 3'd5;
        #1;
        n_cmp++;
        if ({bus.dbgData, bus.carryFlag} !== {16'h2469, 1'b0}) begin
            n_err++;
            $display("FAIL adc_r5: R5=%h C=%b, required 2469 0", bus.dbgData, bus.carryFlag);
        end
        run_instr(enc(2'd0, 3'd2, 3'd6, 3'd1, 3'd1));
        bus.dbgAddr = 3'd6;
        #1;
        n_cmp++;
        if ({bus.dbgData, bus.zeroFlag, bus.negativeFlag} !== {16'h0000, 2'b10}) begin
            n_err++;
            $display("FAIL sub_r6: R6=%h ZN=%b, required 0000 10", bus.dbgData, {bus.zeroFlag, bus.negativeFlag});
        end
        run_instr(enc(2'd1, 3'd0, 3'd7, 3'd3, 3'd3));
        bus.dbgAddr = 3'd7;
        #1;
        n_cmp++;
        if ({bus.dbgData, bus.carryFlag, bus.negativeFlag} !== {16'hFFFE, 2'b11}) begin
            n_err++;
            $display("FAIL shl_r7: R7=%h CN=%b, required FFFE 11", bus.dbgData, {bus.carryFlag, bus.negativeFlag});
        end
    endtask

    task automatic test_illegal();
        run_instr(16'hC000);
        run_instr({2'b11, 14'($urandom)});
        run_instr(rand_instr(0));
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins;
        logic [1:0]  last_c;
        int          acc;
        acc = 0;
        last_c = 2'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ins = rand_instr(0);
            bus.instrIn = ins;
            bus.instrValid = 1'b1;
            n_cmp++;
            if ({bus.instrReady, bus.done, bus.illegal, en_w} !==
                {k % 3 == 0, k > 0 && k % 3 == 0, 1'b0, (k % 3 == 2) ? (3'b001 << last_c) : 3'b000}) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: rdy/done/ill/en=%b, required rdy=%0d done=%0d en=%b", k,
                         {bus.instrReady, bus.done, bus.illegal, en_w}, k % 3 == 0, k > 0 && k % 3 == 0,
                         (k % 3 == 2) ? (3'b001 << last_c) : 3'b000);
            end
            if (bus.instrReady === 1'b1) begin
                model_apply(ins);
                last_c = ins[15:14];
                acc++;
            end
        end
        @(negedge clk);
        bus.instrValid = 1'b0;
        n_cmp++;
        if ({bus.done, bus.instrReady, en_w, acc} !== {2'b11, 3'b000, 32'd10}) begin
            n_err++;
            $display("FAIL b2b_end: done=%b rdy=%b en=%b accepted=%0d, required 1 1 000 10",
                     bus.done, bus.instrReady, en_w, acc);
        end
        n_cmp++;
        if ({bus.carryFlag, bus.zeroFlag, bus.negativeFlag} !== {m_c, m_z, m_n}) begin
            n_err++;
            $display("FAIL b2b_flags: CZN=%b, required %b", {bus.carryFlag, bus.zeroFlag, bus.negativeFlag}, {m_c, m_z, m_n});
        end
        for (int r = 0; r < 8; r++) begin
            bus.dbgAddr = 3'(r);
            #1;
            n_cmp++;
            if (bus.dbgData !== m_reg[r]) begin
                n_err++;
                $display("FAIL b2b_reg R%0d: got %h, required %h", r, bus.dbgData, m_reg[r]);
            end
        end
    endtask

    task automatic test_reset_abort();
        run_instr(imm(3'd6, 3'd1, 8'h5A));
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            bus.instrIn = enc(2'd0, 3'd0, 3'd2, 3'd1, 3'd1);
            bus.instrValid = 1'b1;
            @(posedge clk);
            #1 bus.instrValid = 1'b0;
            @(negedge clk);
            if (p == 1) @(negedge clk);
            n_cmp++;
            if (en_w !== ((p == 1) ? 3'b001 : 3'b000)) begin
                n_err++;
                $display("FAIL abort_stage%0d: en=%b before reset, required %b", p, en_w, (p == 1) ? 3'b001 : 3'b000);
            end
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_reset();
            for (int q = 0; q < 2; q++) begin
                n_cmp++;
                if ({bus.instrReady, bus.done, bus.illegal, en_w} !== 6'b100000) begin
                    n_err++;
                    $display("FAIL abort%0d_cycle%0d: rdy/done/ill/en=%b, required 100000", p, q,
                             {bus.instrReady, bus.done, bus.illegal, en_w});
                end
                @(negedge clk);
            end
            n_cmp++;
            if ({bus.carryFlag, bus.zeroFlag, bus.negativeFlag, bus.aluOperand1, bus.aluOperand2,
                 bus.aluOperation, bus.aluCarryIn} !== 39'h0) begin
                n_err++;
                $display("FAIL abort%0d_state: CZN=%b op1=%h op2=%h op=%0d ci=%b, required all zero", p,
                         {bus.carryFlag, bus.zeroFlag, bus.negativeFlag}, bus.aluOperand1, bus.aluOperand2,
                         bus.aluOperation, bus.aluCarryIn);
            end
            bus.dbgAddr = 3'd2;
            #1;
            n_cmp++;
            if (bus.dbgData !== 16'h0000) begin
                n_err++;
                $display("FAIL abort%0d_r2: R2=%h, required 0000", p, bus.dbgData);
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int r = 0; r < 8; r++) begin
            run_instr(imm(3'd6, 3'(r), 8'($urandom)));
            run_instr(imm(3'd5, 3'(r), 8'($urandom)));
        end
        for (int i = 0; i < 40; i++) run_instr(rand_instr(1));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.instrValid = 1'b0;
        bus.instrIn = 16'h0000;
        bus.dbgAddr = 3'd0;
        model_reset();
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
